// File: rtl/expr_eval_ctrl.sv
// rtl/expr_eval_ctrl.sv - character-stream expression evaluator (digit (op digit)* '='), '*' before '+'
// Optional overflow detection: define EXPR_OVF_EN.
module expr_eval_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    output logic             in_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] result,
    output logic             res_err,
    output logic             ovf,
    output logic             busy
);

`ifdef EXPR_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef enum logic [2:0] {EXP_DIG, EXP_OP, MUL, ERR, DONE} state_t;
    state_t state, state_d;

    logic [WIDTH-1:0] sum, term, mcand, prod;
    logic [3:0]       mplier;
    logic [1:0]       mcnt;
    logic             mul_pend, frame_act, ovf_st;

    logic             acc, is_dig, is_eq, is_plus, is_star;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH+3:0] pp_ext, prod_ext;
    logic             sum_c, mul_c, ovf_fin;

    assign acc     = in_valid && in_ready;
    assign is_dig  = (in_char >= "0") && (in_char <= "9");
    assign is_eq   = (in_char == "=");
    assign is_plus = (in_char == "+");
    assign is_star = (in_char == "*");

    // Extended sums expose the carry out of WIDTH bits for overflow tracking.
    assign sum_ext  = {1'b0, sum} + {1'b0, term};
    assign pp_ext   = mplier[mcnt] ? ({4'b0000, mcand} << mcnt) : '0;
    assign prod_ext = {4'b0000, prod} + pp_ext;
    assign sum_c    = OVF_EN && sum_ext[WIDTH];
    assign mul_c    = OVF_EN && (prod_ext[WIDTH+3:WIDTH] != 4'd0);
    assign ovf_fin  = ovf_st || sum_c;

    assign in_ready  = (state == EXP_DIG) || (state == EXP_OP) || (state == ERR);
    assign res_valid = (state == DONE);
    assign busy      = (state == MUL) || (state == DONE) || frame_act;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= EXP_DIG;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            EXP_DIG: if (acc) begin
                if (is_dig)     state_d = mul_pend ? MUL : EXP_OP;
                else if (is_eq) state_d = DONE;
                else            state_d = ERR;
            end
            EXP_OP: if (acc) begin
                if (is_plus || is_star) state_d = EXP_DIG;
                else if (is_eq)         state_d = DONE;
                else                    state_d = ERR;
            end
            MUL:     if (mcnt == 2'd3) state_d = EXP_OP;
            ERR:     if (acc && is_eq) state_d = DONE;
            DONE:    state_d = EXP_DIG;
            default: state_d = EXP_DIG;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sum <= '0; term <= '0; mcand <= '0; prod <= '0;
            mplier <= '0; mcnt <= '0;
            mul_pend <= 1'b0; frame_act <= 1'b0; ovf_st <= 1'b0;
            result <= '0; res_err <= 1'b0; ovf <= 1'b0;
        end else begin
            if (acc) frame_act <= 1'b1;
            case (state)
                EXP_DIG: if (acc) begin
                    if (is_dig) begin
                        if (mul_pend) begin
                            mcand  <= term;
                            mplier <= in_char[3:0];
                            prod   <= '0;
                            mcnt   <= '0;
                        end else begin
                            term <= {{(WIDTH-4){1'b0}}, in_char[3:0]};
                        end
                    end else if (is_eq) begin
                        result  <= '0;
                        res_err <= 1'b1;
                        ovf     <= ovf_st;
                    end
                end
                EXP_OP: if (acc) begin
                    if (is_plus) begin
                        sum      <= sum_ext[WIDTH-1:0];
                        mul_pend <= 1'b0;
                        ovf_st   <= ovf_st || sum_c;
                    end else if (is_star) begin
                        mul_pend <= 1'b1;
                    end else if (is_eq) begin
                        result  <= ovf_fin ? '0 : sum_ext[WIDTH-1:0];
                        res_err <= ovf_fin;
                        ovf     <= ovf_fin;
                    end
                end
                MUL: begin
                    prod   <= prod_ext[WIDTH-1:0];
                    mcnt   <= mcnt + 2'd1;
                    ovf_st <= ovf_st || mul_c;
                    if (mcnt == 2'd3) begin
                        term     <= prod_ext[WIDTH-1:0];
                        mul_pend <= 1'b0;
                    end
                end
                ERR: if (acc && is_eq) begin
                    result  <= '0;
                    res_err <= 1'b1;
                    ovf     <= ovf_st;
                end
                DONE: begin
                    sum <= '0; term <= '0;
                    mul_pend <= 1'b0; frame_act <= 1'b0; ovf_st <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// tb/tb_expr_eval_ctrl.sv - directed self-checking bench for expr_eval_ctrl
module tb_expr_eval_ctrl;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        in_ready, res_valid, res_err, ovf, busy;
    logic [15:0] result;
    logic        in_ready8, res_valid8, res_err8, ovf8, busy8;
    logic [7:0]  result8;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int low_cnt = 0;
    logic [15:0] cap_result;
    logic        cap_err, cap_ovf;
    logic [7:0]  cap_result8;
    logic        cap_err8, cap_ovf8;

    always #5 clk = ~clk;

    expr_eval_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .res_valid(res_valid), .result(result),
        .res_err(res_err), .ovf(ovf), .busy(busy)
    );

    expr_eval_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready8), .res_valid(res_valid8), .result(result8),
        .res_err(res_err8), .ovf(ovf8), .busy(busy8)
    );

    always @(negedge clk) begin
        if (res_valid) begin
            pulses++;
            cap_result = result; cap_err = res_err; cap_ovf = ovf;
            cap_result8 = result8; cap_err8 = res_err8; cap_ovf8 = ovf8;
        end
        if (!in_ready && !res_valid) low_cnt++;
    end

    task automatic send_chars(input string s);
        for (int i = 0; i < s.len(); i++) begin
            int n = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_char  = s[i];
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!in_ready) begin
                $display("FAIL accept_timeout char=%s in_ready=%b required=1", s.substr(i, i), in_ready);
                errors++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string s, input logic [15:0] exp_res, input logic exp_err);
        int p0 = pulses;
        int n = 0;
        low_cnt = 0;
        send_chars(s);
        while (pulses == p0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pulses != p0 + 1) begin
            $display("FAIL pulses[%s] got=%0d required=1", s, pulses - p0);
            errors++;
        end
        checks++;
        if (cap_result !== exp_res) begin
            $display("FAIL result[%s] got=%0d required=%0d", s, cap_result, exp_res);
            errors++;
        end
        checks++;
        if (cap_err !== exp_err) begin
            $display("FAIL res_err[%s] got=%b required=%b", s, cap_err, exp_err);
            errors++;
        end
        checks++;
        if (cap_ovf !== 1'b0) begin
            $display("FAIL ovf[%s] got=%b required=0", s, cap_ovf);
            errors++;
        end
        checks++;
        if (result !== exp_res || res_err !== exp_err) begin
            $display("FAIL hold[%s] got=%0d/%b required=%0d/%b", s, result, res_err, exp_res, exp_err);
            errors++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({res_valid, result, res_err, ovf, busy, in_ready} !== {1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset_outputs got=%b/%0d/%b/%b/%b/%b required=0/0/0/0/0/1",
                     res_valid, result, res_err, ovf, busy, in_ready);
            errors++;
        end
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_precedence;
        run_frame("3+4*5=", 16'd23, 1'b0);
        checks++;
        if (low_cnt != 4) begin
            $display("FAIL mul_stall_cycles got=%0d required=4", low_cnt);
            errors++;
        end
    endtask

    task automatic test_mul_chain;
        run_frame("2*3*4=", 16'd24, 1'b0);
        run_frame("9*9*9*9*9=", 16'd59049, 1'b0);
    endtask

    task automatic test_err_recover;
        run_frame("12+3=", 16'd0, 1'b1);
        run_frame("7=", 16'd7, 1'b0);
    endtask

    task automatic test_malformed;
        run_frame("3+=", 16'd0, 1'b1);
        run_frame("=", 16'd0, 1'b1);
        run_frame("a+1=", 16'd0, 1'b1);
    endtask

    task automatic test_width8;
        logic [7:0] er;
        logic       ee, eo;
`ifdef EXPR_OVF_EN
        er = 8'd0; ee = 1'b1; eo = 1'b1;
`else
        er = 8'd217; ee = 1'b0; eo = 1'b0;
`endif
        run_frame("9*9*9=", 16'd729, 1'b0);
        checks++;
        if (cap_result8 !== er || cap_err8 !== ee || cap_ovf8 !== eo) begin
            $display("FAIL width8 got=%0d/%b/%b required=%0d/%b/%b",
                     cap_result8, cap_err8, cap_ovf8, er, ee, eo);
            errors++;
        end
    endtask

    task automatic test_abort;
        int p0;
        @(negedge clk);
        in_valid = 1'b1; in_char = "3"; @(posedge clk);
        @(negedge clk); in_char = "*"; @(posedge clk);
        @(negedge clk); in_char = "7"; @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        p0 = pulses;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL abort_in_mul busy=%b in_ready=%b required=1/0", busy, in_ready);
            errors++;
        end
        clr = 1'b1;
        #1;
        checks++;
        if ({res_valid, result, res_err, ovf, busy} !== 20'd0) begin
            $display("FAIL abort_clear got=%b/%0d/%b/%b/%b required=0/0/0/0/0",
                     res_valid, result, res_err, ovf, busy);
            errors++;
        end
        @(negedge clk);
        clr = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (pulses != p0) begin
            $display("FAIL abort_spurious got=%0d required=0", pulses - p0);
            errors++;
        end
        run_frame("5=", 16'd5, 1'b0);
    endtask

    initial begin
        test_reset();
        test_precedence();
        test_mul_chain();
        test_err_recover();
        test_malformed();
        test_width8();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
